// File: rtl/regfile_write_queue.sv
// rtl/regfile_write_queue.sv - in-order register write-back queue with forwarding lookup; optional REGFILE_WRITE_QUEUE_COALESCE_EN
module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    parameter int ADDRW = 5
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     InValid,
    output logic                     InReady,
    input  logic [ADDRW-1:0]         InRegister,
    input  logic [WIDTH-1:0]         InData,
    input  logic                     DrainEn,
    output logic                     RegWrite,
    output logic [ADDRW-1:0]         WriteRegister,
    output logic [WIDTH-1:0]         WriteData,
    input  logic [ADDRW-1:0]         LookupRegister,
    output logic                     LookupHit,
    output logic [WIDTH-1:0]         LookupData,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Full,
    output logic                     Empty
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;

    logic [PTRW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNTW-1:0]  count_q, count_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [ADDRW-1:0] reg_mem_q [DEPTH];
    logic [ADDRW-1:0] reg_mem_d [DEPTH];
    logic [WIDTH-1:0] data_mem_q [DEPTH];
    logic [WIDTH-1:0] data_mem_d [DEPTH];
    logic             out_vld_q, out_vld_d;
    logic [ADDRW-1:0] out_reg_q, out_reg_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             full, empty, in_ready, pop, accept, push_new, coalesce;
    logic [PTRW-1:0]  lk_idx;

    assign full  = (count_q == CNTW'(DEPTH));
    assign empty = (count_q == '0);
    assign pop   = DrainEn & ~empty;

`ifdef REGFILE_WRITE_QUEUE_COALESCE_EN
    logic [PTRW-1:0] tail_last;
    logic            tail_match;
    assign tail_last  = tail_q - PTRW'(1);
    assign tail_match = ~empty && (reg_mem_q[tail_last] == InRegister) && (InRegister != '0);
    // A full queue can still absorb a request that merges into its tail.
    assign in_ready   = Reset_n & (~full | (InValid & tail_match));
    // A tail leaving on this edge can no longer be merged into.
    assign coalesce   = accept & tail_match & ~(pop & (count_q == CNTW'(1)));
`else
    assign in_ready   = Reset_n & ~full;
    assign coalesce   = 1'b0;
`endif

    // Register 0 writes complete the handshake but are dropped.
    assign accept   = InValid & in_ready;
    assign push_new = accept & (InRegister != '0) & ~coalesce;

    // Next-state for pointers, entries, occupancy and the output stage.
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        vld_d      = vld_q;
        reg_mem_d  = reg_mem_q;
        data_mem_d = data_mem_q;
        out_vld_d  = pop;
        out_reg_d  = out_reg_q;
        out_data_d = out_data_q;
        if (pop) begin
            out_reg_d     = reg_mem_q[head_q];
            out_data_d    = data_mem_q[head_q];
            vld_d[head_q] = 1'b0;
            head_d        = head_q + PTRW'(1);
        end
        if (push_new) begin
            reg_mem_d[tail_q]  = InRegister;
            data_mem_d[tail_q] = InData;
            vld_d[tail_q]      = 1'b1;
            tail_d             = tail_q + PTRW'(1);
        end
`ifdef REGFILE_WRITE_QUEUE_COALESCE_EN
        if (coalesce) begin
            data_mem_d[tail_last] = InData;
        end
`endif
        case ({push_new, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset discards every queued and in-flight write.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            vld_q      <= '0;
            out_vld_q  <= 1'b0;
            out_reg_q  <= '0;
            out_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                reg_mem_q[i]  <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            vld_q      <= vld_d;
            out_vld_q  <= out_vld_d;
            out_reg_q  <= out_reg_d;
            out_data_q <= out_data_d;
            reg_mem_q  <= reg_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

    // Forwarding lookup: oldest first so the newest match wins.
    always_comb begin
        LookupHit  = 1'b0;
        LookupData = '0;
        lk_idx     = '0;
        if (LookupRegister != '0) begin
            if (out_vld_q && (out_reg_q == LookupRegister)) begin
                LookupHit  = 1'b1;
                LookupData = out_data_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                lk_idx = head_q + PTRW'(i);
                if (vld_q[lk_idx] && (reg_mem_q[lk_idx] == LookupRegister)) begin
                    LookupHit  = 1'b1;
                    LookupData = data_mem_q[lk_idx];
                end
            end
        end
    end

    assign InReady       = in_ready;
    assign RegWrite      = out_vld_q;
    assign WriteRegister = out_reg_q;
    assign WriteData     = out_data_q;
    assign Count         = count_q;
    assign Full          = full;
    assign Empty         = empty;

endmodule

// File: tb/tb_regfile_write_queue.sv
// tb/tb_regfile_write_queue.sv - directed self-checking bench for regfile_write_queue
module tb_regfile_write_queue;

    logic        Clk, Reset_n, InValid, InReady, DrainEn, RegWrite, LookupHit, Full, Empty;
    logic [4:0]  InRegister, WriteRegister, LookupRegister;
    logic [31:0] InData, WriteData, LookupData;
    logic [2:0]  Count;

    int vectors = 0;
    int miscompares = 0;

    regfile_write_queue dut (
        .Clk(Clk), .Reset_n(Reset_n), .InValid(InValid), .InReady(InReady),
        .InRegister(InRegister), .InData(InData), .DrainEn(DrainEn),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .LookupRegister(LookupRegister), .LookupHit(LookupHit), .LookupData(LookupData),
        .Count(Count), .Full(Full), .Empty(Empty)
    );

    always #5 Clk = ~Clk;

    task automatic test_reset;
        Reset_n = 0;
        repeat (2) @(negedge Clk);
        vectors++; if (Count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", Count); end
        vectors++; if (Empty !== 1'b1 || Full !== 1'b0) begin miscompares++; $display("FAIL reset_flags: empty %0b full %0b want 1 0", Empty, Full); end
        vectors++; if (InReady !== 1'b0) begin miscompares++; $display("FAIL reset_inready: got %0b want 0", InReady); end
        vectors++; if (RegWrite !== 1'b0 || WriteRegister !== 5'd0 || WriteData !== 32'd0) begin miscompares++; $display("FAIL reset_out: got %0b %0d %0d want 0 0 0", RegWrite, WriteRegister, WriteData); end
        Reset_n = 1;
        @(negedge Clk);
        vectors++; if (InReady !== 1'b1) begin miscompares++; $display("FAIL post_reset_inready: got %0b want 1", InReady); end
    endtask

    task automatic test_latency;
        DrainEn = 1; InValid = 1; InRegister = 5'd2; InData = 32'd42;
        @(negedge Clk);
        InValid = 0;
        vectors++; if (Count !== 3'd1 || RegWrite !== 1'b0) begin miscompares++; $display("FAIL lat_edge0: count %0d regwrite %0b want 1 0", Count, RegWrite); end
        @(negedge Clk);
        vectors++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd2 || WriteData !== 32'd42) begin miscompares++; $display("FAIL lat_edge1: got %0b r%0d %0d want 1 r2 42", RegWrite, WriteRegister, WriteData); end
        @(negedge Clk);
        vectors++; if (RegWrite !== 1'b0 || WriteRegister !== 5'd2) begin miscompares++; $display("FAIL lat_edge2: got %0b r%0d want 0 r2", RegWrite, WriteRegister); end
    endtask

    task automatic test_full;
        int fr[4];
        int fd[4];
        fr = '{2, 2, 3, 14};
        fd = '{50, 10, 60, 15};
        DrainEn = 0;
        for (int k = 0; k < 4; k++) begin
            InValid = 1; InRegister = 5'(fr[k]); InData = 32'(fd[k]);
            @(negedge Clk);
        end
        InRegister = 5'd9; InData = 32'd99;
        vectors++; if (Full !== 1'b1 || InReady !== 1'b0 || Count !== 3'd4) begin miscompares++; $display("FAIL full_flags: full %0b ready %0b count %0d want 1 0 4", Full, InReady, Count); end
        @(negedge Clk);
        InValid = 0;
        vectors++; if (Count !== 3'd4) begin miscompares++; $display("FAIL fifth_push: count %0d want 4", Count); end
        LookupRegister = 5'd9; #1;
        vectors++; if (LookupHit !== 1'b0) begin miscompares++; $display("FAIL lookup_refused: hit %0b want 0", LookupHit); end
        LookupRegister = 5'd2; #1;
        vectors++; if (LookupHit !== 1'b1 || LookupData !== 32'd10) begin miscompares++; $display("FAIL lookup_r2: got %0b %0d want 1 10", LookupHit, LookupData); end
        DrainEn = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            vectors++; if (RegWrite !== 1'b1 || WriteRegister !== 5'(fr[k]) || WriteData !== 32'(fd[k])) begin miscompares++; $display("FAIL drain_%0d: got %0b r%0d %0d want 1 r%0d %0d", k, RegWrite, WriteRegister, WriteData, fr[k], fd[k]); end
            vectors++; if (LookupHit !== (k < 2) || (k < 2 && LookupData !== 32'd10)) begin miscompares++; $display("FAIL drain_lookup_%0d: got %0b %0d want %0b 10", k, LookupHit, LookupData, k < 2); end
        end
        @(negedge Clk);
        vectors++; if (RegWrite !== 1'b0 || Empty !== 1'b1) begin miscompares++; $display("FAIL drain_done: regwrite %0b empty %0b want 0 1", RegWrite, Empty); end
    endtask

    task automatic test_reg0;
        DrainEn = 1; InValid = 1; InRegister = 5'd0; InData = 32'd15; LookupRegister = 5'd0;
        #1;
        vectors++; if (InReady !== 1'b1) begin miscompares++; $display("FAIL r0_ready: got %0b want 1", InReady); end
        vectors++; if (LookupHit !== 1'b0 || LookupData !== 32'd0) begin miscompares++; $display("FAIL r0_lookup: got %0b %0d want 0 0", LookupHit, LookupData); end
        @(negedge Clk);
        InValid = 0;
        vectors++; if (Count !== 3'd0 || Empty !== 1'b1) begin miscompares++; $display("FAIL r0_count: got %0d want 0", Count); end
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk);
            vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL r0_regwrite_%0d: got %0b want 0", k, RegWrite); end
        end
    endtask

    task automatic test_full_pop_wrap;
        logic [36:0] exp_q[$];
        int n_sent;
        bit done;
        DrainEn = 0;
        for (int k = 0; k < 4; k++) begin
            InValid = 1; InRegister = 5'(k + 1); InData = 32'(200 + k);
            exp_q.push_back({5'(k + 1), 32'(200 + k)});
            @(negedge Clk);
        end
        DrainEn = 1; InValid = 1; InRegister = 5'd5; InData = 32'd7; #1;
        vectors++; if (InReady !== 1'b0) begin miscompares++; $display("FAIL popedge_ready: got %0b want 0", InReady); end
        @(negedge Clk);
        vectors++; if (Count !== 3'd3) begin miscompares++; $display("FAIL popedge_count: got %0d want 3", Count); end
        vectors++; if (RegWrite !== 1'b1 || {WriteRegister, WriteData} !== exp_q[0]) begin miscompares++; $display("FAIL popedge_write: got %0b r%0d %0d want 1 r1 200", RegWrite, WriteRegister, WriteData); end
        void'(exp_q.pop_front());
        DrainEn = 0; #1;
        vectors++; if (InReady !== 1'b1) begin miscompares++; $display("FAIL nextedge_ready: got %0b want 1", InReady); end
        @(negedge Clk);
        exp_q.push_back({5'd5, 32'd7});
        vectors++; if (Count !== 3'd4) begin miscompares++; $display("FAIL nextedge_count: got %0d want 4", Count); end
        DrainEn = 1; n_sent = 0; done = 0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            if (n_sent < 12) begin
                InValid = 1; InRegister = 5'(n_sent % 7 + 1); InData = 32'(300 + n_sent); #1;
                if (InReady) begin exp_q.push_back({InRegister, InData}); n_sent++; end
            end else begin
                InValid = 0;
            end
            @(negedge Clk);
            if (RegWrite) begin
                vectors++;
                if (exp_q.size() == 0) begin miscompares++; $display("FAIL wrap_extra: got r%0d %0d want none", WriteRegister, WriteData); end
                else begin
                    if ({WriteRegister, WriteData} !== exp_q[0]) begin miscompares++; $display("FAIL wrap_order: got r%0d %0d want r%0d %0d", WriteRegister, WriteData, exp_q[0][36:32], exp_q[0][31:0]); end
                    void'(exp_q.pop_front());
                end
            end
            done = (n_sent == 12) && (exp_q.size() == 0);
        end
        InValid = 0;
        vectors++; if (!done) begin miscompares++; $display("FAIL wrap_timeout: sent %0d pending %0d want 12 0", n_sent, exp_q.size()); end
        @(negedge Clk);
        vectors++; if (Empty !== 1'b1 || RegWrite !== 1'b0) begin miscompares++; $display("FAIL wrap_end: empty %0b regwrite %0b want 1 0", Empty, RegWrite); end
    endtask

    task automatic test_async_reset;
        DrainEn = 0;
        for (int k = 0; k < 4; k++) begin
            InValid = 1; InRegister = 5'(10 + k); InData = 32'(500 + k);
            @(negedge Clk);
        end
        InValid = 0; DrainEn = 1;
        @(negedge Clk);
        vectors++; if (Count !== 3'd3 || RegWrite !== 1'b1) begin miscompares++; $display("FAIL pre_reset: count %0d regwrite %0b want 3 1", Count, RegWrite); end
        #2 Reset_n = 0;
        #1;
        vectors++; if (RegWrite !== 1'b0 || Count !== 3'd0 || Empty !== 1'b1 || InReady !== 1'b0) begin miscompares++; $display("FAIL async_reset: regwrite %0b count %0d empty %0b ready %0b want 0 0 1 0", RegWrite, Count, Empty, InReady); end
        @(negedge Clk);
        Reset_n = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL post_reset_write_%0d: got %0b r%0d want 0", k, RegWrite, WriteRegister); end
        end
    endtask

    task automatic test_coalesce;
        logic [36:0] got_q[$];
        DrainEn = 0;
        InValid = 1; InRegister = 5'd7; InData = 32'd1;
        @(negedge Clk);
        InData = 32'd2;
        @(negedge Clk);
        InValid = 0;
`ifdef REGFILE_WRITE_QUEUE_COALESCE_EN
        vectors++; if (Count !== 3'd1) begin miscompares++; $display("FAIL coal_count: got %0d want 1", Count); end
`else
        vectors++; if (Count !== 3'd2) begin miscompares++; $display("FAIL coal_count: got %0d want 2", Count); end
`endif
        DrainEn = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            if (RegWrite) got_q.push_back({WriteRegister, WriteData});
        end
`ifdef REGFILE_WRITE_QUEUE_COALESCE_EN
        vectors++; if (got_q.size() != 1 || got_q[0] !== {5'd7, 32'd2}) begin miscompares++; $display("FAIL coal_writes: got %0d writes want 1 of r7 2", got_q.size()); end
`else
        vectors++; if (got_q.size() != 2 || got_q[0] !== {5'd7, 32'd1} || got_q[1] !== {5'd7, 32'd2}) begin miscompares++; $display("FAIL coal_writes: got %0d writes want r7 1 then r7 2", got_q.size()); end
`endif
    endtask

    initial begin
        Clk = 0; Reset_n = 0; InValid = 0; InRegister = '0; InData = '0;
        DrainEn = 0; LookupRegister = '0;
        test_reset;
        test_latency;
        test_full;
        test_reg0;
        test_full_pop_wrap;
        test_async_reset;
        test_coalesce;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
- Buffered write-back stage directly upstream of the 32x32 register file.
- Accepts register write requests from producers over a valid/ready handshake, queues them in order, and drains them one per cycle onto the regfile's WriteRegister/WriteData/RegWrite port.
- Provides a newest-first lookup port so that read logic can forward pending, not-yet-committed data.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16
- WIDTH, 32, data width
- ADDRW, 5, register address width

Ports:
- Clk  in  1  clock; all state changes on the positive edge
- Reset_n  in  1  asynchronous, active-low reset
- InValid  in  1  producer has a write request
- InReady  out  1  queue can accept this cycle
- InRegister  in  ADDRW  destination register
- InData  in  WIDTH  write data
- DrainEn  in  1  regfile may accept a write this cycle
- RegWrite  out  1  write enable to regfile (registered)
- WriteRegister  out  ADDRW  regfile write address (registered)
- WriteData  out  WIDTH  regfile write data (registered)
- LookupRegister  in  ADDRW  register being read downstream
- LookupHit  out  1  a pending write to LookupRegister exists
- LookupData  out  WIDTH  data of newest pending write to LookupRegister
- Count  out  clog2(DEPTH)+1  queued entries; excludes the output stage
- Full  out  1  Count==DEPTH
- Empty  out  1  Count==0

Behaviour:
- Reset (Reset_n low, asynchronous, any time):
  - Count=0, Empty=1, Full=0, InReady=0 while Reset_n low.
  - RegWrite=0, WriteRegister=0, WriteData=0.
  - Head and tail pointers cleared; all entry valid bits cleared. Entry contents are don't-care.
  - Reset mid-operation discards all queued and in-flight writes; nothing reaches the regfile.
- Handshake:
  - InReady = Reset_n & !Full.
  - Accept on an edge where InValid & InReady; the request enqueues at the tail.
  - A request whose InRegister is 0 is accepted, consumes the handshake, and is discarded (not queued), because register 0 is constant zero.
- Pop:
  - On an edge where DrainEn & !Empty, the head entry moves into the output stage; the next cycle RegWrite=1, WriteRegister and WriteData hold that entry.
  - Otherwise RegWrite=0 the next cycle. WriteRegister and WriteData hold their last values.
- Latency: acceptance into an empty queue at edge N gives RegWrite=1 after edge N+1, so the regfile commits at edge N+2. Maximum throughput is one write per cycle.
- Simultaneous push and pop: allowed whenever !Full, and Count is unchanged. When Full, push is refused even if a pop occurs on the same edge; InReady depends only on current state.
- Ordering: strict FIFO. Writes to the same register commit in acceptance order.
- Pointers are ADDRW-independent log2(DEPTH)-bit counters that wrap modulo DEPTH. Count is tracked separately so Full and Empty are never ambiguous.
- Lookup (combinational from state and LookupRegister):
  - Searches queued entries from tail to head, then the output stage while RegWrite=1.
  - LookupHit=1 with LookupData from the newest match.
  - No match, or LookupRegister==0: LookupHit=0, LookupData=0.
  - Same-cycle InData is not visible to lookup.
- DrainEn low stalls the drain indefinitely with no loss; entries and lookup remain valid.

Optional Feature:
- Macro: REGFILE_WRITE_QUEUE_COALESCE_EN
- Defined:
  - If an accepted request targets the same register as the current tail entry, and that tail is not being popped on the same edge, the tail's data is overwritten and Count is unchanged.
  - InReady = Reset_n & (!Full | (InValid & tail match)).
- Undefined: every non-zero-register request occupies a new entry, with behaviour exactly as above.

Test Plan:
- Reset, DrainEn=1, push {r2, 42}:
  - RegWrite=1, WriteRegister=2, WriteData=42 exactly two edges after acceptance, then RegWrite=0.
- DrainEn=0, push {r2,50}, {r2,10}, {r3,60}, {r14,15}:
  - Full=1, InReady=0, fifth push refused.
  - LookupRegister=2 gives LookupHit=1, LookupData=10.
  - Set DrainEn=1: four consecutive RegWrite cycles in push order.
- Push {r0, 15}:
  - InReady handshake completes, Count stays 0, RegWrite never asserts.
  - LookupRegister=0 gives LookupHit=0.
- Full queue, DrainEn=1, InValid held with {r5, 7}:
  - No acceptance on the popping edge.
  - Accepted on the next edge; Count returns to DEPTH.
  - Over 3*DEPTH pushes, pointer wrap-around preserves order.
- Assert Reset_n=0 asynchronously mid-drain with 3 entries queued:
  - RegWrite drops immediately, Count=0, Empty=1, and no further writes occur after release.
- COALESCE_EN build, DrainEn=0, push {r7,1}, then {r7,2}:
  - Count=1.
  - Drain produces a single write {r7, 2}.
  - Without the macro, two writes occur: {r7,1} then {r7,2}.
